// File: rtl/judge_unit_if.sv
// ============================================================================
// judge_unit_if : answer/judgement link between the player board and referee
// Rev 1.0
// ============================================================================
`default_nettype none

interface judge_unit_if;
    logic       NEW_GAME;
    logic       QUE_LOAD;
    logic [3:0] EXP1;
    logic [3:0] EXP2;
    logic [3:0] EXP3;
    logic       ANS_VALID;
    logic [3:0] COUNT1_IN;
    logic [3:0] COUNT2_IN;
    logic [3:0] COUNT3_IN;
    logic [1:0] JUDG;
    logic [1:0] HP;
    logic       WRONG;

    modport master (
        output NEW_GAME, QUE_LOAD, EXP1, EXP2, EXP3,
        output ANS_VALID, COUNT1_IN, COUNT2_IN, COUNT3_IN,
        input  JUDG, HP, WRONG
    );

    modport slave (
        input  NEW_GAME, QUE_LOAD, EXP1, EXP2, EXP3,
        input  ANS_VALID, COUNT1_IN, COUNT2_IN, COUNT3_IN,
        output JUDG, HP, WRONG
    );
endinterface

`default_nettype wire

// File: rtl/judge_unit.sv
// ============================================================================
// judge_unit : referee for the 1P game link (judging, lives, lockout, game over)
// Rev 1.0
// ============================================================================
`default_nettype none

module judge_unit #(
    parameter int HP_INIT        = 3,
    parameter int SHOW_CYCLES    = 50000000,
    parameter int PENALTY_CYCLES = 100000000,
    parameter int TIMER_W        = 27
) (
    input  wire               CLK,
    input  wire               RST,
    judge_unit_if.slave       bus
);

    localparam logic [TIMER_W-1:0] SHOW_LOAD    = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PENALTY_LOAD = TIMER_W'(PENALTY_CYCLES - 1);
    localparam logic [1:0]         HP_RESET     = 2'(HP_INIT);

    localparam logic [1:0] J_NONE  = 2'b00;
    localparam logic [1:0] J_RIGHT = 2'b01;
    localparam logic [1:0] J_WRONG = 2'b10;
    localparam logic [1:0] J_OVER  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CHECK   = 3'd2,
        S_SHOW    = 3'd3,
        S_PENALTY = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    state_t               state_q;
    logic [1:0]           judg_q;
    logic [1:0]           hp_q;
    logic                 wrong_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [3:0]           exp1_q, exp2_q, exp3_q;
    logic [3:0]           cnt1_q, cnt2_q, cnt3_q;
    logic                 ans_prev_q;

    logic submit;
    logic match;
    logic timer_done;

    assign submit     = bus.ANS_VALID & ~ans_prev_q;
    assign match      = (cnt1_q == exp1_q) && (cnt2_q == exp2_q) && (cnt3_q == exp3_q);
    assign timer_done = (timer_q == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ans_prev_q <= 1'b0;
            state_q    <= S_IDLE;
            judg_q     <= J_NONE;
            hp_q       <= HP_RESET;
            wrong_q    <= 1'b0;
            timer_q    <= '0;
            exp1_q     <= '0;
            exp2_q     <= '0;
            exp3_q     <= '0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            cnt3_q     <= '0;
        end else begin
            // The edge detector keeps following the player LED even on a new game,
            // so a level still held high then does not count as a fresh submit.
            ans_prev_q <= bus.ANS_VALID;
            if (bus.NEW_GAME) begin
                state_q <= S_IDLE;
                judg_q  <= J_NONE;
                hp_q    <= HP_RESET;
                wrong_q <= 1'b0;
                timer_q <= '0;
                exp1_q  <= '0;
                exp2_q  <= '0;
                exp3_q  <= '0;
                cnt1_q  <= '0;
                cnt2_q  <= '0;
                cnt3_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.QUE_LOAD) begin
                            exp1_q  <= bus.EXP1;
                            exp2_q  <= bus.EXP2;
                            exp3_q  <= bus.EXP3;
                            state_q <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        judg_q <= J_NONE;
                        if (bus.QUE_LOAD) begin
                            exp1_q <= bus.EXP1;
                            exp2_q <= bus.EXP2;
                            exp3_q <= bus.EXP3;
                        end else if (submit) begin
                            cnt1_q  <= bus.COUNT1_IN;
                            cnt2_q  <= bus.COUNT2_IN;
                            cnt3_q  <= bus.COUNT3_IN;
                            state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (match) begin
                            judg_q  <= J_RIGHT;
                            timer_q <= SHOW_LOAD;
                            state_q <= S_SHOW;
                        end else if (hp_q <= 2'd1) begin
                            hp_q    <= 2'd0;
                            judg_q  <= J_OVER;
                            wrong_q <= 1'b0;
                            state_q <= S_OVER;
                        end else begin
                            hp_q    <= hp_q - 2'd1;
                            judg_q  <= J_WRONG;
                            wrong_q <= 1'b1;
                            timer_q <= PENALTY_LOAD;
                            state_q <= S_PENALTY;
                        end
                    end
                    S_SHOW: begin
                        if (bus.QUE_LOAD) begin
                            exp1_q  <= bus.EXP1;
                            exp2_q  <= bus.EXP2;
                            exp3_q  <= bus.EXP3;
                            judg_q  <= J_NONE;
                            state_q <= S_ARMED;
                        end else if (timer_done) begin
                            judg_q  <= J_NONE;
                            state_q <= S_IDLE;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    S_PENALTY: begin
                        if (timer_done) begin
                            wrong_q <= 1'b0;
                            judg_q  <= J_NONE;
                            state_q <= S_ARMED;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    S_OVER: begin
                        judg_q  <= J_OVER;
                        hp_q    <= 2'd0;
                        wrong_q <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        judg_q  <= J_NONE;
                        wrong_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.JUDG  = judg_q;
    assign bus.HP    = hp_q;
    assign bus.WRONG = wrong_q;

endmodule

`default_nettype wire

// File: tb/tb_judge_unit.sv
// ============================================================================
// tb_judge_unit : directed table, corner sequences and random run for judge_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_judge_unit;

    localparam int SHOW    = 4;
    localparam int PEN     = 6;
    localparam int HP_INIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    judge_unit_if bus();

    judge_unit #(
        .HP_INIT        (HP_INIT),
        .SHOW_CYCLES    (SHOW),
        .PENALTY_CYCLES (PEN),
        .TIMER_W        (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int vectors = 0;
    int fails   = 0;

    // ---------------- reference model (deadline based) ----------------
    int          cyc = 0;
    bit          m_q;
    logic [11:0] m_exp, m_cnt;
    int          m_eval, m_show_end, m_pen_end;
    logic [1:0]  m_judg, m_hp;
    bit          m_wrong, m_over, m_prev;

    task automatic model_clear();
        m_q = 0; m_exp = '0; m_cnt = '0;
        m_eval = -1; m_show_end = -1; m_pen_end = -1;
        m_judg = 2'd0; m_hp = 2'(HP_INIT); m_wrong = 0; m_over = 0;
    endtask

    task automatic model_edge(input bit r, input bit ng, input bit ql, input logic [11:0] e,
                              input bit av, input logic [11:0] c);
        bit sub;
        cyc++;
        if (r) begin model_clear(); m_prev = 0; return; end
        sub    = av && !m_prev;
        m_prev = av;
        if (ng) begin model_clear(); return; end
        if (m_over) return;
        if (m_eval == cyc) begin
            m_eval = -1;
            if (m_cnt == m_exp) begin
                m_judg = 2'd1; m_show_end = cyc + SHOW; m_q = 0;
            end else if (m_hp == 2'd1) begin
                m_hp = 2'd0; m_judg = 2'd3; m_wrong = 0; m_over = 1;
            end else begin
                m_hp = m_hp - 2'd1; m_judg = 2'd2; m_wrong = 1; m_pen_end = cyc + PEN;
            end
            return;
        end
        if (m_pen_end >= cyc) begin
            if (m_pen_end == cyc) begin m_wrong = 0; m_judg = 2'd0; m_pen_end = -1; end
            return;
        end
        if (ql) begin
            m_exp = e; m_q = 1; m_judg = 2'd0; m_show_end = -1;
            return;
        end
        if (m_show_end >= cyc) begin
            if (m_show_end == cyc) begin m_judg = 2'd0; m_show_end = -1; end
            return;
        end
        if (m_q && sub) begin m_cnt = c; m_eval = cyc + 1; end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [4:0] outs();
        return {bus.JUDG, bus.HP, bus.WRONG};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @cyc %0d: got J/HP/W=%b required %b", name, cyc, act, req);
        end
    endtask

    task automatic tick(input bit r, input bit ng, input bit ql, input logic [11:0] e,
                        input bit av, input logic [11:0] c);
        rst = r;
        bus.NEW_GAME = ng; bus.QUE_LOAD = ql;
        {bus.EXP1, bus.EXP2, bus.EXP3} = e;
        bus.ANS_VALID = av;
        {bus.COUNT1_IN, bus.COUNT2_IN, bus.COUNT3_IN} = c;
        @(posedge clk);
        model_edge(r, ng, ql, e, av, c);
        #1;
        chk("model", outs(), {m_judg, m_hp, m_wrong});
    endtask

    task automatic idle(input int n, input bit av, input logic [11:0] c);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 12'h000, av, c);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        bit          r;
        bit          ng;
        bit          ql;
        logic [11:0] e;
        bit          av;
        logic [11:0] c;
        logic [1:0]  j;
        logic [1:0]  hp;
        bit          w;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit ql, input logic [11:0] e, input bit av,
                                input logic [11:0] c, input logic [1:0] j, input logic [1:0] hp,
                                input bit w);
        vec_t v;
        v.r = r; v.ng = 0; v.ql = ql; v.e = e; v.av = av; v.c = c;
        v.j = j; v.hp = hp; v.w = w;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int jumps;
        logic [1:0] pj;
        logic [11:0] re, rc;

        bus.NEW_GAME = 0; bus.QUE_LOAD = 0; bus.ANS_VALID = 0;
        {bus.EXP1, bus.EXP2, bus.EXP3} = '0;
        {bus.COUNT1_IN, bus.COUNT2_IN, bus.COUNT3_IN} = '0;
        model_clear(); m_prev = 0;

        // correct answer, then wrong answer with retry
        tbl.push_back(mk(1, 0, 12'h000, 0, 12'h000, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 1, 12'h210, 0, 12'h000, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 0, 12'h000, 1, 12'h210, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 0, 12'h000, 1, 12'h210, 2'd1, 2'd3, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 2'd1, 2'd3, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 0, 12'h000, 1, 12'h210, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 1, 12'h210, 0, 12'h000, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 0, 12'h000, 1, 12'h110, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 2'd2, 2'd2, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 2'd2, 2'd2, 1));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 2'd0, 2'd2, 0));
        tbl.push_back(mk(0, 0, 12'h000, 1, 12'h210, 2'd0, 2'd2, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 2'd1, 2'd2, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].ng, tbl[i].ql, tbl[i].e, tbl[i].av, tbl[i].c);
            chk($sformatf("table[%0d]", i), outs(), {tbl[i].j, tbl[i].hp, tbl[i].w});
        end

        // game over after three misses
        tick(0, 1, 0, 12'h000, 0, 12'h000);
        tick(0, 0, 1, 12'h305, 0, 12'h000);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 12'h000, 1, 12'h304);
            tick(0, 0, 0, 12'h000, 0, 12'h000);
            if (k == 0) chk("over_hp2", outs(), {2'd2, 2'd2, 1'b1});
            if (k == 1) chk("over_hp1", outs(), {2'd2, 2'd1, 1'b1});
            if (k == 2) chk("over_enter", outs(), {2'd3, 2'd0, 1'b0});
            idle(PEN + 1, 0, 12'h000);
        end
        tick(0, 0, 0, 12'h000, 1, 12'h305);
        tick(0, 0, 1, 12'h305, 0, 12'h000);
        idle(3, 0, 12'h000);
        chk("over_hold", outs(), {2'd3, 2'd0, 1'b0});
        tick(0, 1, 0, 12'h000, 0, 12'h000);
        chk("newgame", outs(), {2'd0, 2'd3, 1'b0});
        tick(0, 0, 0, 12'h000, 1, 12'h000);
        idle(2, 0, 12'h000);
        chk("idle_ignores", outs(), {2'd0, 2'd3, 1'b0});

        // lockout toggles, level hold, QUE_LOAD beats submit
        tick(0, 0, 1, 12'h123, 0, 12'h000);
        tick(0, 0, 0, 12'h000, 1, 12'h122);
        tick(0, 0, 0, 12'h000, 0, 12'h000);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 12'h000, (i % 2 == 0), 12'h123);
        chk("lockout_hold", outs(), {2'd2, 2'd2, 1'b1});
        idle(PEN, 0, 12'h000);
        chk("lockout_exit", outs(), {2'd0, 2'd2, 1'b0});
        jumps = 0;
        for (int i = 0; i < 20; i++) begin
            pj = bus.JUDG;
            tick(0, 0, 0, 12'h000, 1, 12'h123);
            if (pj == 2'd0 && bus.JUDG != 2'd0) jumps++;
        end
        vectors++;
        if (jumps != 1) begin
            fails++;
            $display("FAIL level_hold: got %0d judgments required 1", jumps);
        end
        tick(0, 0, 0, 12'h000, 0, 12'h000);
        tick(0, 0, 1, 12'h444, 1, 12'h444);
        idle(2, 0, 12'h000);
        chk("ql_drops_submit", outs(), {2'd0, 2'd2, 1'b0});
        tick(0, 0, 0, 12'h000, 1, 12'h444);
        tick(0, 0, 0, 12'h000, 0, 12'h000);
        chk("ql_latched", outs(), {2'd1, 2'd2, 1'b0});
        tick(0, 0, 1, 12'h000, 0, 12'h000);
        chk("show_ql_clears", outs(), {2'd0, 2'd2, 1'b0});
        tick(0, 0, 0, 12'h000, 1, 12'h000);
        tick(0, 0, 0, 12'h000, 0, 12'h000);
        chk("zero_counts", outs(), {2'd1, 2'd2, 1'b0});

        // reset during penalty with one life left
        tick(0, 1, 0, 12'h000, 0, 12'h000);
        tick(0, 0, 1, 12'h555, 0, 12'h000);
        for (int k = 0; k < 2; k++) begin
            tick(0, 0, 0, 12'h000, 1, 12'h554);
            tick(0, 0, 0, 12'h000, 0, 12'h000);
            if (k == 0) idle(PEN + 1, 0, 12'h000);
        end
        idle(2, 0, 12'h000);
        chk("pen_hp1", outs(), {2'd2, 2'd1, 1'b1});
        tick(1, 0, 0, 12'h000, 0, 12'h000);
        chk("mid_reset", outs(), {2'd0, 2'd3, 1'b0});
        tick(0, 0, 0, 12'h000, 1, 12'h555);
        idle(2, 0, 12'h000);
        chk("reset_idle", outs(), {2'd0, 2'd3, 1'b0});
        tick(0, 0, 1, 12'h555, 0, 12'h000);
        tick(0, 0, 0, 12'h000, 1, 12'h555);
        tick(0, 0, 0, 12'h000, 0, 12'h000);
        chk("reset_reload", outs(), {2'd1, 2'd3, 1'b0});

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            re = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)),
                  2'b00, 2'($urandom_range(0, 3))};
            rc = ($urandom_range(0, 1) == 1) ? m_exp
                 : {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)),
                    2'b00, 2'($urandom_range(0, 3))};
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 11) == 0, re,
                 ($urandom_range(0, 3) == 0) ? ~bus.ANS_VALID : bus.ANS_VALID, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
